// File: rtl/read_iq_multi.sv
// Byte-stream I/Q deinterleaver: assembles little-endian signed I/Q samples per channel,
// sign-extends and left-shifts them. Optional READ_IQ_SAMPLE_CNT_EN adds sample_count.
module read_iq_multi #(
  parameter int DATA_SIZE        = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int BITS             = 10,
  parameter int CHANNELS         = 1,
  parameter int CH_W             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BYTE_SIZE-1:0] in_dout,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic [DATA_SIZE-1:0] i_out_din,
  output logic [DATA_SIZE-1:0] q_out_din,
  output logic [CH_W-1:0]      ch_out,
  input  logic                 i_out_full,
  input  logic                 q_out_full,
  output logic                 i_out_wr_en,
  output logic                 q_out_wr_en
`ifdef READ_IQ_SAMPLE_CNT_EN
  ,
  output logic [31:0]          sample_count
`endif
);

  localparam int NB   = 2 * BYTES_PER_SAMPLE;
  localparam int SW   = BYTES_PER_SAMPLE * BYTE_SIZE;
  localparam int BC_W = $clog2(NB);

  typedef enum logic {S_READ, S_WRITE} state_t;

  state_t                 state_q, state_d;
  logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0]        ch_out_q, ch_out_d;
  logic [NB*BYTE_SIZE-1:0] shreg_q, shreg_d;
  logic [DATA_SIZE-1:0]   i_q, i_d, q_q, q_d;
  logic signed [SW-1:0]   i_raw, q_raw;
  logic signed [DATA_SIZE-1:0] i_ext, q_ext;
  logic                   pop, wr, last_byte;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_READ;
      byte_cnt_q <= '0;
      ch_cnt_q   <= '0;
      ch_out_q   <= '0;
      shreg_q    <= '0;
      i_q        <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      ch_out_q   <= ch_out_d;
      shreg_q    <= shreg_d;
      i_q        <= i_d;
      q_q        <= q_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    ch_out_d   = ch_out_q;
    shreg_d    = shreg_q;
    i_d        = i_q;
    q_d        = q_q;

    pop       = (state_q == S_READ) && !in_empty;
    wr        = (state_q == S_WRITE) && !i_out_full && !q_out_full;
    last_byte = pop && (byte_cnt_q == BC_W'(NB - 1));

    // Bytes enter at the top so the first (I LSB) byte ends up lowest.
    if (pop) begin
      shreg_d    = {in_dout, shreg_q[NB*BYTE_SIZE-1:BYTE_SIZE]};
      byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
    end

    i_raw = shreg_d[SW-1:0];
    q_raw = shreg_d[2*SW-1:SW];
    i_ext = DATA_SIZE'(i_raw);
    q_ext = DATA_SIZE'(q_raw);

    if (last_byte) begin
      i_d      = i_ext <<< BITS;
      q_d      = q_ext <<< BITS;
      ch_out_d = ch_cnt_q;
      state_d  = S_WRITE;
    end

    if (wr) begin
      state_d  = S_READ;
      ch_cnt_d = (ch_cnt_q == CH_W'(CHANNELS - 1)) ? '0 : ch_cnt_q + 1'b1;
    end
  end

  assign in_rd_en    = pop;
  assign i_out_wr_en = wr;
  assign q_out_wr_en = wr;
  assign i_out_din   = i_q;
  assign q_out_din   = q_q;
  assign ch_out      = ch_out_q;

`ifdef READ_IQ_SAMPLE_CNT_EN
  logic [31:0] sample_count_q;

  always_ff @(posedge clock) begin
    if (!reset)  sample_count_q <= '0;
    else if (wr) sample_count_q <= sample_count_q + 32'd1;
  end

  assign sample_count = sample_count_q;
`endif

endmodule

// File: tb/tb_read_iq_multi.sv
// Bench for read_iq_multi: three instances (default, 1-byte samples, two channels)
// checked every cycle against a byte-stream model, plus literal expectations.
module tb_read_iq_multi;

  logic        clock;
  logic        reset;
  logic [7:0]  din   [3];
  logic        emp   [3];
  logic        ifull [3];
  logic        qfull [3];
  logic        rd    [3];
  logic        iwr   [3];
  logic        qwr   [3];
  logic [31:0] iod   [3];
  logic [31:0] qod   [3];
  logic [0:0]  cho   [3];
`ifdef READ_IQ_SAMPLE_CNT_EN
  logic [31:0] scnt_o [3];
`endif

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  logic chk_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) ncyc <= ncyc + 1;

  read_iq_multi u_def (
    .clock(clock), .reset(reset), .in_dout(din[0]), .in_empty(emp[0]), .in_rd_en(rd[0]),
    .i_out_din(iod[0]), .q_out_din(qod[0]), .ch_out(cho[0]),
    .i_out_full(ifull[0]), .q_out_full(qfull[0]), .i_out_wr_en(iwr[0]), .q_out_wr_en(qwr[0])
`ifdef READ_IQ_SAMPLE_CNT_EN
    , .sample_count(scnt_o[0])
`endif
  );

  read_iq_multi #(.BYTES_PER_SAMPLE(1)) u_b1 (
    .clock(clock), .reset(reset), .in_dout(din[1]), .in_empty(emp[1]), .in_rd_en(rd[1]),
    .i_out_din(iod[1]), .q_out_din(qod[1]), .ch_out(cho[1]),
    .i_out_full(ifull[1]), .q_out_full(qfull[1]), .i_out_wr_en(iwr[1]), .q_out_wr_en(qwr[1])
`ifdef READ_IQ_SAMPLE_CNT_EN
    , .sample_count(scnt_o[1])
`endif
  );

  read_iq_multi #(.CHANNELS(2)) u_c2 (
    .clock(clock), .reset(reset), .in_dout(din[2]), .in_empty(emp[2]), .in_rd_en(rd[2]),
    .i_out_din(iod[2]), .q_out_din(qod[2]), .ch_out(cho[2]),
    .i_out_full(ifull[2]), .q_out_full(qfull[2]), .i_out_wr_en(iwr[2]), .q_out_wr_en(qwr[2])
`ifdef READ_IQ_SAMPLE_CNT_EN
    , .sample_count(scnt_o[2])
`endif
  );

  function automatic int bps_of(input int k);
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic int ch_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  // Signed little-endian value times 2^10, truncated to 32 bits.
  function automatic logic [31:0] quant(input int bps, input logic [7:0] lo, input logic [7:0] hi);
    longint v;
    if (bps == 2) begin
      v = longint'(lo) + 256 * longint'(hi);
      if (v >= 32768) v = v - 65536;
    end else begin
      v = longint'(lo);
      if (v >= 128) v = v - 256;
    end
    return 32'(v * 1024);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: bytes popped, pair pending until both FIFOs have room.
  logic [7:0]  mb   [3][4];
  int          nb   [3];
  int          fr   [3];
  logic        pend [3];
  logic [31:0] ai   [3];
  logic [31:0] aq   [3];
  logic [0:0]  ach  [3];
  logic [31:0] mcnt [3];

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        nb[k] = 0; fr[k] = 0; pend[k] = 1'b0;
        ai[k] = '0; aq[k] = '0; ach[k] = '0; mcnt[k] = '0;
      end else if (pend[k]) begin
        if (!ifull[k] && !qfull[k]) begin
          pend[k] = 1'b0;
          fr[k]++;
          mcnt[k] = mcnt[k] + 32'd1;
        end
      end else if (!emp[k]) begin
        mb[k][nb[k]] = din[k];
        nb[k]++;
        if (nb[k] == 2 * bps_of(k)) begin
          nb[k] = 0;
          if (bps_of(k) == 2) begin
            ai[k] = quant(2, mb[k][0], mb[k][1]);
            aq[k] = quant(2, mb[k][2], mb[k][3]);
          end else begin
            ai[k] = quant(1, mb[k][0], 8'h00);
            aq[k] = quant(1, mb[k][1], 8'h00);
          end
          ach[k]  = 1'(fr[k] % ch_of(k));
          pend[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rd_en[%0d]", k), 32'(rd[k]), 32'(!pend[k] && !emp[k]));
        chk($sformatf("i_wr[%0d]", k), 32'(iwr[k]), 32'(pend[k] && !ifull[k] && !qfull[k]));
        chk($sformatf("q_wr[%0d]", k), 32'(qwr[k]), 32'(pend[k] && !ifull[k] && !qfull[k]));
        chk($sformatf("i_din[%0d]", k), iod[k], ai[k]);
        chk($sformatf("q_din[%0d]", k), qod[k], aq[k]);
        chk($sformatf("ch_out[%0d]", k), 32'(cho[k]), 32'(ach[k]));
`ifdef READ_IQ_SAMPLE_CNT_EN
        chk($sformatf("sample_count[%0d]", k), scnt_o[k], mcnt[k]);
`endif
      end
    end
  end

  // Offer one byte and return just after it is popped.
  task automatic feed(input int k, input logic [7:0] b, output int pc);
    int n;
    pc = -1;
    din[k] = b;
    emp[k] = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clock);
      if (rd[k]) break;
    end
    if (n == 40) begin
      chk("feed_timeout", 32'd1, 32'd0);
    end else begin
      pc = ncyc;
    end
    @(posedge clock);
    #1;
    emp[k] = 1'b1;
  endtask

  task automatic wait_wr(input int k, output logic [31:0] iv, output logic [31:0] qv,
                         output logic [0:0] c, output int wc);
    int n;
    iv = '0; qv = '0; c = '0; wc = -1;
    for (n = 0; n < 40; n++) begin
      @(negedge clock);
      if (iwr[k]) break;
    end
    if (n == 40) begin
      chk("wr_timeout", 32'd1, 32'd0);
    end else begin
      iv = iod[k]; qv = qod[k]; c = cho[k]; wc = ncyc;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic feed4(input int k, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, output int first);
    int pc;
    feed(k, b0, first);
    feed(k, b1, pc);
    feed(k, b2, pc);
    feed(k, b3, pc);
  endtask

  task automatic count_wr(input int k, input int ncycles, output int nw);
    nw = 0;
    for (int n = 0; n < ncycles; n++) begin
      @(negedge clock);
      if (iwr[k] || qwr[k]) nw++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] iv, qv;
    logic [0:0]  c;
    int          first, pc, wc, nw, nrd;

    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0; emp[k] = 1'b1; ifull[k] = 1'b0; qfull[k] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset_i_din", iod[0], 32'h0);
    chk("reset_rd_en", 32'(rd[0]), 32'h0);
    chk("reset_wr_en", 32'(iwr[0]), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Default params: basic pair and latency
    feed4(0, 8'h34, 8'h12, 8'hCD, 8'hAB, first);
    wait_wr(0, iv, qv, c, wc);
    chk("def_i", iv, 32'h0048D000);
    chk("def_q", qv, 32'hFEAF3400);
    chk("def_ch", 32'(c), 32'h0);
    chk("def_latency", 32'(wc - first + 1), 32'd5);

    // One byte per component
    feed(1, 8'h7F, pc);
    feed(1, 8'h80, pc);
    wait_wr(1, iv, qv, c, wc);
    chk("b1_i", iv, 32'h0001FC00);
    chk("b1_q", qv, 32'hFFFE0000);

    // Two channels, three frames
    feed4(2, 8'h10, 8'h00, 8'h20, 8'h00, first);
    wait_wr(2, iv, qv, c, wc);
    chk("c2_ch0", 32'(c), 32'h0);
    chk("c2_i0", iv, 32'h00004000);
    chk("c2_q0", qv, 32'h00008000);
    feed4(2, 8'hF0, 8'hFF, 8'h01, 8'h00, first);
    wait_wr(2, iv, qv, c, wc);
    chk("c2_ch1", 32'(c), 32'h1);
    chk("c2_i1", iv, 32'hFFFFC000);
    chk("c2_q1", qv, 32'h00000400);
    feed4(2, 8'h00, 8'h00, 8'h00, 8'h00, first);
    wait_wr(2, iv, qv, c, wc);
    chk("c2_ch2", 32'(c), 32'h0);
`ifdef READ_IQ_SAMPLE_CNT_EN
    @(negedge clock);
    chk("c2_count", scnt_o[2], 32'd3);
    @(posedge clock);
    #1;
`endif

    // Downstream Q FIFO full: pair held, no pop even with bytes waiting
    qfull[0] = 1'b1;
    feed4(0, 8'h01, 8'h00, 8'hFF, 8'hFF, first);
    din[0] = 8'h55;
    emp[0] = 1'b0;
    nw = 0; nrd = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (iwr[0] || qwr[0]) nw++;
      if (rd[0]) nrd++;
      chk("stall_i_hold", iod[0], 32'h00000400);
      chk("stall_q_hold", qod[0], 32'hFFFFFC00);
    end
    chk("stall_writes", 32'(nw), 32'd0);
    chk("stall_pops", 32'(nrd), 32'd0);
    @(posedge clock);
    #1;
    emp[0]   = 1'b1;
    qfull[0] = 1'b0;
    count_wr(0, 4, nw);
    chk("release_writes", 32'(nw), 32'd1);

    // Upstream empty for 7 cycles mid-sample
    feed(0, 8'h00, pc);
    feed(0, 8'h80, pc);
    nrd = 0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clock);
      if (rd[0]) nrd++;
    end
    chk("gap_pops", 32'(nrd), 32'd0);
    @(posedge clock);
    #1;
    feed(0, 8'hFF, pc);
    feed(0, 8'h7F, pc);
    wait_wr(0, iv, qv, c, wc);
    chk("gap_i", iv, 32'hFE000000);
    chk("gap_q", qv, 32'h01FFFC00);

    // Reset after a partial sample
    feed(0, 8'h11, pc);
    feed(0, 8'h22, pc);
    feed(0, 8'h33, pc);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_i", iod[0], 32'h0);
    @(posedge clock);
    #1;
    feed4(0, 8'h78, 8'h56, 8'h00, 8'h00, first);
    wait_wr(0, iv, qv, c, wc);
    chk("rst_i", iv, 32'h0159E000);
    chk("rst_q", qv, 32'h00000000);
    chk("rst_ch", 32'(c), 32'h0);
`ifdef READ_IQ_SAMPLE_CNT_EN
    @(negedge clock);
    chk("rst_count", scnt_o[0], 32'd1);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
